// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: NOP encoding, reset vector default and FSM states.
// The misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_WORD         = 32'h00000013;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h00000000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_HALT = 2'd3
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding word read, 1-entry output skid buffer.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into S_HALT.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = fetch_unit_pkg::RESET_VECTOR_DEF,
    parameter logic [31:0] NOP_WORD     = fetch_unit_pkg::NOP_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_misaligned
);
    import fetch_unit_pkg::*;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rpc_q, rpc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] opc_q, opc_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic        mis_q, mis_d;

    logic blocked;
    logic hs;
    logic xfer;
    logic inflight;

    // A request only goes out when the output slot is free or leaving now
    assign blocked   = valid_q && !i_ready;
    assign o_mem_req = !i_rst && (state_q == S_REQ) && !blocked;
    assign o_mem_addr = pc_q;
    assign hs        = o_mem_req && i_mem_ack;
    assign xfer      = valid_q && i_ready;
    assign inflight  = hs || ((state_q == S_WAIT || drop_q) && !i_mem_rvalid);

    assign o_instr = instr_q;
    assign o_pc    = opc_q;
    assign o_valid = valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign o_misaligned = mis_q;
`else
    assign o_misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        mis_d   = mis_q;

        if (xfer) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end

        unique case (state_q)
            S_REQ: begin
                if (hs) begin
                    rpc_d   = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_d = i_mem_rdata;
                        opc_d   = rpc_q;
                        valid_d = 1'b1;
                        pc_d    = rpc_q + 32'd4;
                        state_d = i_ready ? S_REQ : S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (xfer) begin
                    state_d = S_REQ;
                end
            end
            S_HALT: begin
                if (i_mem_rvalid) begin
                    drop_d = 1'b0;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides everything; a pending response must be dropped
        if (i_redirect) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            pc_d    = word_align(i_redirect_pc);
            drop_d  = inflight;
            state_d = inflight ? S_WAIT : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_d = (i_redirect_pc[1:0] != 2'b00);
            if (mis_d) begin
                state_d = S_HALT;
            end
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_VECTOR;
            rpc_q   <= 32'd0;
            instr_q <= NOP_WORD;
            opc_q   <= 32'd0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit with a latency-programmable memory.
// Honours FETCH_MISALIGN_TRAP_EN to select the misaligned-redirect expectation.
module tb_fetch_unit;

    localparam logic [31:0] XM  = 32'hA5A5A5A5;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] o_mem_addr;
    logic        o_mem_req;
    logic        i_mem_ack;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_valid;
    logic        i_ready;
    logic        o_misaligned;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sb[$];
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'd0;

    fetch_unit dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_mem_addr   (o_mem_addr),
        .o_mem_req    (o_mem_req),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_misaligned (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Memory: responds mem_lat cycles after each accepted request
    always @(negedge i_clk) begin
        #3;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'd0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = mem_addr ^ XM;
            end
        end
        if (o_mem_req && i_mem_ack) begin
            mem_addr = o_mem_addr;
            mem_cnt  = mem_lat;
        end
    end

    // Monitor: scoreboard pop on each transfer plus per-cycle invariants
    always @(negedge i_clk) begin
        logic [31:0] e;
        #2;
        if (!i_rst) begin
            if (o_valid && i_ready) begin
                e = (sb.size() != 0) ? sb.pop_front() : 32'hDEADBEEF;
                chk("xfer_pc", o_pc, e);
                chk("xfer_instr", o_instr, e ^ XM);
            end
            if (!o_valid)
                chk("nop_idle", o_instr, NOP);
            if (o_valid && !i_ready)
                chk("no_req_full", 32'(o_mem_req), 32'd0);
            if (o_mem_req)
                chk("addr_align", 32'(o_mem_addr[1:0]), 32'd0);
        end
    end

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (o_valid) break;
            @(negedge i_clk);
            #1;
        end
        chk(tag, 32'(o_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0) break;
            @(negedge i_clk);
            #1;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
        i_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] pc);
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        @(negedge i_clk);
        #1;
        i_redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        i_rst         = 1'b1;
        i_ready       = 1'b1;
        i_mem_ack     = 1'b1;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_instr", o_instr, NOP);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_req", 32'(o_mem_req), 32'd0);
        chk("rst_mis", 32'(o_misaligned), 32'd0);

        // Sequential fetch from the reset vector, first output 2 cycles later
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        sb.push_back(32'h8);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        chk("lat_cyc1_valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        #1;
        chk("lat_cyc2_valid", 32'(o_valid), 32'd1);
        chk("lat_cyc2_pc", o_pc, 32'h0);

        // Stall with pc 8 in the output register
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            #1;
            if (o_valid && o_pc == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        i_ready = 1'b0;
        chk("reach_pc8", 32'(found), 32'd1);
        repeat (4) begin
            @(negedge i_clk);
            #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_pc", o_pc, 32'h8);
            chk("hold_instr", o_instr, 32'h8 ^ XM);
            chk("hold_req", 32'(o_mem_req), 32'd0);
        end
        @(negedge i_clk);
        #1;
        sb.push_back(32'hC);
        i_ready = 1'b1;

        // Redirect one cycle after the 0x10 request is accepted, slow response
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_mem_req && o_mem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clk);
            #1;
        end
        chk("req_0x10", 32'(found), 32'd1);
        mem_lat = 3;
        @(negedge i_clk);
        #1;
        mem_lat = 1;
        sb.push_back(32'h100);
        redirect(32'h100);
        drain("drain_redir_0x100");

        // Transfer coincident with redirect, then redirect coincident with rvalid
        wait_valid("hold_0x104");
        sb.push_back(32'h104);
        i_ready = 1'b1;
        mem_lat = 2;
        redirect(32'h300);
        i_ready = 1'b0;
        chk("after_redir_valid", 32'(o_valid), 32'd0);
        chk("req_0x300", 32'(o_mem_req), 32'd1);
        chk("addr_0x300", o_mem_addr, 32'h300);
        @(negedge i_clk);
        @(negedge i_clk);
        #1;
        mem_lat = 1;
        sb.push_back(32'h400);
        redirect(32'h400);
        chk("rv_redir_valid", 32'(o_valid), 32'd0);
        chk("rv_redir_req", 32'(o_mem_req), 32'd1);
        chk("rv_redir_addr", o_mem_addr, 32'h400);
        i_ready = 1'b1;
        drain("drain_0x400");

        // PC adder wrap at the top of the address space
        wait_valid("hold_0x404");
        sb.push_back(32'hFFFFFFFC);
        sb.push_back(32'h0);
        redirect(32'hFFFFFFFC);
        i_ready = 1'b1;
        drain("drain_wrap");

        // Misaligned redirect
        wait_valid("hold_after_wrap");
        redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_set", 32'(o_misaligned), 32'd1);
        chk("mis_valid", 32'(o_valid), 32'd0);
        repeat (3) begin
            @(negedge i_clk);
            #1;
            chk("halt_req", 32'(o_mem_req), 32'd0);
            chk("halt_mis", 32'(o_misaligned), 32'd1);
        end
        sb.push_back(32'h200);
        redirect(32'h200);
        chk("mis_clear", 32'(o_misaligned), 32'd0);
        chk("resume_addr", o_mem_addr, 32'h200);
`else
        chk("mis_tied", 32'(o_misaligned), 32'd0);
        chk("masked_req", 32'(o_mem_req), 32'd1);
        chk("masked_addr", o_mem_addr, 32'h100);
        sb.push_back(32'h100);
`endif
        i_ready = 1'b1;
        drain("drain_misalign");

        @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
